tick_sched: RTL
===============

# tick_sched

Programmable alarm scheduler for the 1 kHz system tick. It holds `CHANNELS` alarm channels, each with a compare value and an optional reload period. A single shared comparator is time-multiplexed across the channels by a round-robin scan. Firing channels latch pending bits that drive one registered, maskable interrupt line. The block sits on the peripheral bus next to the ticker, consumes its bus-domain tick count, and is configured entirely through bus registers.

## Interface
- `CHANNELS`, default 4: number of alarm channels, legal range 1..8.
- `clk_bus` input 1: bus clock; the only clock.
- `rst_n` input 1: asynchronous active-low reset.
- `tick_count` input 32: tick count already in the `clk_bus` domain (1 ms per LSB).
- `irq` output 1: registered interrupt, `|(pending & mask)`.
- `bus_data_o` output 32: read data; combinational, `bus_read ? reg[bus_address] : 0`.
- `bus_address` input 8: byte address; bits [1:0] ignored.
- `bus_data_i` input 32: write data.
- `bus_read` input 1: read strobe.
- `bus_write` input 1: write strobe; the write is applied at the rising `clk_bus` edge.

## Operation
- Register map:
  - 0x00 `GCTRL`: bit0 global enable (GEN), RW.
  - 0x04 `PENDING`: bits [CHANNELS-1:0]; read returns the bits, writing 1 to a bit clears it (W1C).
  - 0x08 `MASK`: RW.
  - 0x0C `NOW`: read-only `tick_count`.
  - 0x10 `OVERRUN`: see Configuration.
  - Channel i at 0x20+0x10*i: +0x0 `CMP` RW; +0x4 `PER` RW; +0x8 `CCTRL` (bit0 EN, bit1 PERIODIC) RW; +0xC reserved.
- Unmapped addresses, reserved offsets and channels ≥ CHANNELS read 0 and ignore writes. Unused high bits read 0.
- Scan pointer `ptr` visits channel 0..CHANNELS-1 and then wraps to 0.
  - It advances one step every cycle while GEN=1.
  - It holds at 0 while GEN=0.
- Each cycle with GEN=1, channel `ptr` is evaluated.
  - Fire condition: EN=1 and `(tick_count - CMP)[31] == 0`. This is a 32-bit modular difference, so it is wrap-safe for deltas below 2^31.
  - On fire, `PENDING[ptr]` is set to 1.
  - PERIODIC=1 and PER≠0: `CMP <= CMP + PER` (mod 2^32); EN stays 1.
  - Otherwise (one-shot, or PER=0): EN is cleared.
- Catch-up: if the reloaded `CMP` is still due, the channel fires again on its next visit.
- Simultaneous events on the same cycle:
  - A bus write to the `CMP` or `CCTRL` of the channel being fired wins over the hardware reload or EN clear.
  - A W1C to a pending bit on the same cycle it fires leaves the bit at 1 (set wins).
  - A write of GEN=0 stops the scan from the next cycle on; the evaluation on that cycle still completes.
- Reset mid-operation clears every register, `ptr` and `irq` immediately. No alarm survives reset.

## Timing
- Reset values: all registers 0, `ptr`=0, `irq`=0.
  - `bus_data_o` is 0 whenever `bus_read`=0.
- Fire latency:
  - A channel becomes due when `tick_count` reaches `CMP`.
  - `PENDING` sets at the edge where `ptr` equals that channel. This is at most CHANNELS cycles after `tick_count` changes.
  - `irq` asserts one cycle after `PENDING`/`MASK` change.
- Clear latency: after a W1C of the last unmasked pending bit, `irq` drops one cycle after the write edge.
- Read data is combinational on the current register state. A write is visible to reads on the cycle after its edge.
- The tick period (≥10^4 bus cycles) far exceeds the scan period, so no tick is missed.

## Configuration
- `TICK_SCHED_OVERRUN_EN` defined:
  - `OVERRUN` (0x10) bit i is set when channel i fires while `PENDING[i]` is already 1, including a same-cycle W1C of that bit.
  - `OVERRUN` is W1C and does not affect `irq`.
- Not defined: 0x10 reads 0, writes are ignored, and no overrun logic is synthesized.

## Test plan
- One-shot fire:
  - Stimulus: `CMP0`=100, `CCTRL0`=1, `MASK`=1, GEN=1, ramp `tick_count` 98→101.
  - Required: `PENDING`=1 within 4 cycles of `tick_count`=100; `irq`=1 one cycle later; EN0 reads 0.
  - Then W1C `PENDING`=1: `irq`=0 one cycle later.
- Periodic reload:
  - Stimulus: `CMP1`=10, `PER1`=5, `CCTRL1`=3, step `tick_count` 10,15,20.
  - Required: `CMP1` reads 15,20,25 after the respective fires; EN1 stays 1.
- Wrap-around:
  - Stimulus: `CMP2`=0x00000002, `tick_count`=0xFFFFFFF0.
  - Required: no fire. After `tick_count`=0x00000002, the channel fires.
- Simultaneous fire and W1C:
  - Stimulus: issue the W1C of bit 3 on the exact fire cycle of channel 3.
  - Required: `PENDING[3]` stays 1; with the macro defined, `OVERRUN[3]`=1.
- Mask and GEN gating:
  - Stimulus: channel due with `MASK`=0; then clear GEN.
  - Required: `PENDING` set but `irq`=0. With GEN=0, a further due channel never fires.
- Async reset: assert `rst_n`=0 mid-scan with `irq`=1; all registers, `irq` and `bus_data_o` read 0 immediately.

Source files
------------

// File: rtl/tick_sched.sv
// tick_sched: CHANNELS alarm channels scanned round-robin against the bus-domain tick count.
// Define TICK_SCHED_OVERRUN_EN to add the W1C OVERRUN register at 0x10.
module tick_sched #(
  parameter int unsigned CHANNELS = 4
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic [31:0] tick_count,
  output logic        irq,
  output logic [31:0] bus_data_o,
  input  logic [7:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write
);
  localparam int unsigned PtrW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(CHANNELS - 1);

  logic                gen_q, gen_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] periodic_q, periodic_d;
  logic [31:0]         cmp_q [CHANNELS];
  logic [31:0]         cmp_d [CHANNELS];
  logic [31:0]         per_q [CHANNELS];
  logic [31:0]         per_d [CHANNELS];
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic                irq_q;

  // Address decode: blk selects the 16-byte block, off the word inside it.
  logic [3:0] blk, ch_idx;
  logic [1:0] off;
  logic       ch_hit, unused_addr;
  logic       wr_gctrl, wr_pending, wr_mask;

  assign blk         = bus_address[7:4];
  assign off         = bus_address[3:2];
  assign ch_idx      = blk - 4'd2;
  assign ch_hit      = (blk >= 4'd2) && ({28'd0, ch_idx} < CHANNELS);
  assign unused_addr = ^bus_address[1:0];
  assign wr_gctrl    = bus_write && (blk == 4'd0) && (off == 2'd0);
  assign wr_pending  = bus_write && (blk == 4'd0) && (off == 2'd1);
  assign wr_mask     = bus_write && (blk == 4'd0) && (off == 2'd2);

  // Shared comparator on the channel under the scan pointer.
  logic [31:0]         cur_cmp, diff;
  logic                cur_en, fire;
  logic [CHANNELS-1:0] fire_vec;

  always_comb begin
    cur_cmp = '0;
    cur_en  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ptr_q == PtrW'(c)) begin
        cur_cmp = cmp_q[c];
        cur_en  = en_q[c];
      end
    end
    diff = tick_count - cur_cmp;
    fire = gen_q && cur_en && !diff[31];
    for (int c = 0; c < CHANNELS; c++) begin
      fire_vec[c] = fire && (ptr_q == PtrW'(c));
    end
  end

  always_comb begin
    gen_d      = gen_q;
    pending_d  = pending_q;
    mask_d     = mask_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    cmp_d      = cmp_q;
    per_d      = per_q;
    if (wr_pending) pending_d = pending_q & ~bus_data_i[CHANNELS-1:0];
    if (wr_mask)    mask_d    = bus_data_i[CHANNELS-1:0];
    if (wr_gctrl)   gen_d     = bus_data_i[0];
    for (int c = 0; c < CHANNELS; c++) begin
      // Hardware update first so a same-cycle bus write to CMP/CCTRL takes precedence.
      if (fire_vec[c]) begin
        pending_d[c] = 1'b1;
        if (periodic_q[c] && (per_q[c] != 32'd0)) cmp_d[c] = cmp_q[c] + per_q[c];
        else                                       en_d[c]  = 1'b0;
      end
      if (bus_write && ch_hit && (ch_idx == 4'(c))) begin
        case (off)
          2'd0: cmp_d[c] = bus_data_i;
          2'd1: per_d[c] = bus_data_i;
          2'd2: begin
            en_d[c]       = bus_data_i[0];
            periodic_d[c] = bus_data_i[1];
          end
          default: ;
        endcase
      end
    end
    if (!gen_d || !gen_q)     ptr_d = '0;
    else if (ptr_q == PtrLast) ptr_d = '0;
    else                      ptr_d = ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      gen_q      <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      en_q       <= '0;
      periodic_q <= '0;
      ptr_q      <= '0;
      irq_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cmp_q[c] <= '0;
        per_q[c] <= '0;
      end
    end else begin
      gen_q      <= gen_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ptr_q      <= ptr_d;
      irq_q      <= |(pending_q & mask_q);
      cmp_q      <= cmp_d;
      per_q      <= per_d;
    end
  end

  assign irq = irq_q;

`ifdef TICK_SCHED_OVERRUN_EN
  logic [CHANNELS-1:0] overrun_q, overrun_d;
  logic                wr_overrun;

  assign wr_overrun = bus_write && (blk == 4'd1) && (off == 2'd0);

  // Set wins over a same-cycle W1C; pending_q sees the bit before any W1C this cycle.
  always_comb begin
    overrun_d = wr_overrun ? (overrun_q & ~bus_data_i[CHANNELS-1:0]) : overrun_q;
    overrun_d = overrun_d | (fire_vec & pending_q);
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) overrun_q <= '0;
    else        overrun_q <= overrun_d;
  end
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (blk == 4'd0) begin
      case (off)
        2'd0: rdata = {31'd0, gen_q};
        2'd1: rdata = 32'(pending_q);
        2'd2: rdata = 32'(mask_q);
        2'd3: rdata = tick_count;
      endcase
`ifdef TICK_SCHED_OVERRUN_EN
    end else if ((blk == 4'd1) && (off == 2'd0)) begin
      rdata = 32'(overrun_q);
`endif
    end else if (ch_hit) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_idx == 4'(c)) begin
          case (off)
            2'd0:    rdata = cmp_q[c];
            2'd1:    rdata = per_q[c];
            2'd2:    rdata = {30'd0, periodic_q[c], en_q[c]};
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  assign bus_data_o = bus_read ? rdata : 32'd0;

endmodule
